axi_rd_arbiter: RTL and testbench

Read-request arbiter sitting between the fetch stage (instruction SRAM-like port) and the execute/memory stages (data SRAM-like port) on one side, and a single AXI3 read-address/read-data channel pair on the other. It grants one requester per AR transaction with fixed data-over-instruction priority and tags each transaction with an ARID. It tracks outstanding reads per ID and steers R beats back to the owning requester as registered `data_ok` pulses.

---
 rtl/axi_rd_arbiter_pkg.sv | 27 ++
 rtl/axi_rd_arbiter_if.sv | 65 ++++++
 rtl/axi_rd_arbiter_outst_cnt.sv | 37 +++
 rtl/axi_rd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter shared types and constants.
// Imported by the interface, counter and top.
package axi_rd_arbiter_pkg;

  localparam logic [3:0] ARID_INST = 4'd0;
  localparam logic [3:0] ARID_DATA = 4'd1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    AR_IDLE,
    AR_BUSY
  } ar_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_req_t;

  function automatic logic [2:0] to_arsize(
    input logic [1:0] i_size
  );
    return {1'b0, i_size};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester ports plus AXI3 AR/R channels.
// master: the arbiter; slave: requesters and AXI slave.
interface axi_rd_arbiter_if;

  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic        rid_err;

  modport master (
    input  inst_req, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_size, data_addr,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output rid_err
  );

  modport slave (
    output inst_req, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_size, data_addr,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  rid_err
  );

endinterface

// File: rtl/axi_rd_arbiter_outst_cnt.sv
// Outstanding-read counter for one ARID.
// Saturates at MAX_OUT, ignores decrement at zero.
module outst_cnt #(
  parameter int MAX_OUT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [1:0] o_cnt,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_udf
);

  localparam logic [1:0] MAX_C = MAX_OUT[1:0];

  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else begin
      unique case ({i_inc, i_dec})
        2'b10: if (r_cnt < MAX_C) r_cnt <= r_cnt + 2'd1;
        2'b01: if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt >= MAX_C);
  assign o_empty = (r_cnt == 2'd0);
  assign o_udf   = i_dec & ~i_inc & o_empty;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-port read arbiter onto one AXI3 AR/R pair.
// Data beats inst; R beats steered back by RID.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_rd_arbiter_if.master  bus
);

  ar_state_e   r_state;
  ar_state_e   w_state_nxt;
  ar_req_t     r_ar;
  ar_req_t     w_ar_nxt;
  logic        w_grant_d;
  logic        w_grant_i;

  logic        r_rready;
  logic        r_inst_ok;
  logic        r_data_ok;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_rid_err;

  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_inc_i;
  logic        w_inc_d;
  logic        w_dec_i;
  logic        w_dec_d;
  logic        w_bad_rid;

  logic        w_full_i;
  logic        w_full_d;
  logic        w_empty_i;
  logic        w_empty_d;
  logic        w_udf_i;
  logic        w_udf_d;
  logic [1:0]  w_cnt_i;
  logic [1:0]  w_cnt_d;
  logic        w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    unique case (r_state)
      AR_IDLE: begin
        if (bus.data_req && !w_full_d)
          w_grant_d = 1'b1;
        else if (bus.inst_req && !w_full_i)
          w_grant_i = 1'b1;
        if (w_grant_d || w_grant_i)
          w_state_nxt = AR_BUSY;
      end
      AR_BUSY: begin
        if (bus.arready)
          w_state_nxt = AR_IDLE;
      end
    endcase
  end

  always_comb begin
    w_ar_nxt = r_ar;
    if (w_grant_d) begin
      w_ar_nxt.id   = ARID_DATA;
      w_ar_nxt.addr = bus.data_addr;
      w_ar_nxt.size = to_arsize(bus.data_size);
    end else if (w_grant_i) begin
      w_ar_nxt.id   = ARID_INST;
      w_ar_nxt.addr = bus.inst_addr;
      w_ar_nxt.size = to_arsize(bus.inst_size);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= AR_IDLE;
      r_ar    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ar    <= w_ar_nxt;
    end
  end

  assign w_ar_hs = bus.arvalid & bus.arready;
  assign w_r_hs  = bus.rvalid & r_rready;
  assign w_inc_i = w_ar_hs & (r_ar.id == ARID_INST);
  assign w_inc_d = w_ar_hs & (r_ar.id == ARID_DATA);
  assign w_dec_i = w_r_hs & (bus.rid == ARID_INST);
  assign w_dec_d = w_r_hs & (bus.rid == ARID_DATA);
  assign w_bad_rid = w_r_hs & ~w_dec_i & ~w_dec_d;

  outst_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_inst (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_inc   (w_inc_i),
    .i_dec   (w_dec_i),
    .o_cnt   (w_cnt_i),
    .o_full  (w_full_i),
    .o_empty (w_empty_i),
    .o_udf   (w_udf_i)
  );

  outst_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_data (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_inc   (w_inc_d),
    .i_dec   (w_dec_d),
    .o_cnt   (w_cnt_d),
    .o_full  (w_full_d),
    .o_empty (w_empty_d),
    .o_udf   (w_udf_d)
  );

  // Single-beat reads: the returned word goes straight to its owner.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rready     <= 1'b0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
      r_rid_err    <= 1'b0;
    end else begin
      r_rready  <= 1'b1;
      r_inst_ok <= w_dec_i;
      r_data_ok <= w_dec_d;
      if (w_dec_i) r_inst_rdata <= bus.rdata;
      if (w_dec_d) r_data_rdata <= bus.rdata;
      r_rid_err <= r_rid_err | w_bad_rid
                 | w_udf_i | w_udf_d;
    end
  end

  assign bus.inst_addr_ok = w_grant_i;
  assign bus.data_addr_ok = w_grant_d;
  assign bus.inst_data_ok = r_inst_ok;
  assign bus.data_data_ok = r_data_ok;
  assign bus.inst_rdata   = r_inst_rdata;
  assign bus.data_rdata   = r_data_rdata;

  assign bus.arvalid = (r_state == AR_BUSY);
  assign bus.arid    = r_ar.id;
  assign bus.araddr  = r_ar.addr;
  assign bus.arsize  = r_ar.size;
  assign bus.arlen   = 8'd0;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = 2'd0;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.rready  = r_rready;
  assign bus.rid_err = r_rid_err;

  assign w_unused = ^{bus.rresp, bus.rlast, w_cnt_i,
                      w_cnt_d, w_empty_i, w_empty_d};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios
// plus a randomized run against a transaction-level model.
module tb_axi_rd_arbiter;

  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.inst_req  = 1'b0;
    bus.inst_size = 2'd0;
    bus.inst_addr = 32'd0;
    bus.data_req  = 1'b0;
    bus.data_size = 2'd0;
    bus.data_addr = 32'd0;
    bus.arready   = 1'b0;
    bus.rid       = 4'd0;
    bus.rdata     = 32'd0;
    bus.rresp     = 2'd0;
    bus.rlast     = 1'b1;
    bus.rvalid    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one data read and complete its AR handshake.
  task automatic data_rd(input logic [31:0] a);
    bus.data_req  = 1'b1;
    bus.data_addr = a;
    bus.data_size = 2'd2;
    tick();
    bus.data_req = 1'b0;
    bus.arready  = 1'b1;
    tick();
    bus.arready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus.arvalid, bus.araddr, bus.arid, bus.arsize} !== '0) begin
      failures++;
      $display("FAIL reset_ar got=%b/%h/%h/%h exp=0", bus.arvalid,
               bus.araddr, bus.arid, bus.arsize);
    end
    checks++;
    if ({bus.inst_data_ok, bus.data_data_ok, bus.rready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ok got=%b%b%b exp=000", bus.inst_data_ok,
               bus.data_data_ok, bus.rready);
    end
    checks++;
    if ({bus.inst_rdata, bus.data_rdata, bus.rid_err} !== '0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h/%b exp=0", bus.inst_rdata,
               bus.data_rdata, bus.rid_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.rready !== 1'b1) begin
      failures++;
      $display("FAIL rready_after_reset got=%b exp=1", bus.rready);
    end
    checks++;
    if ({bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot}
        !== {8'd0, 2'b01, 2'd0, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL ar_const got=%h/%b/%b/%h/%h exp=0/01/0/0/0",
               bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot);
    end
  endtask

  task automatic test_single_inst();
    do_reset();
    bus.inst_req  = 1'b1;
    bus.inst_size = 2'd2;
    bus.inst_addr = 32'h1C00_0000;
    mid();
    checks++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) begin
      failures++;
      $display("FAIL single_addr_ok got=%b%b exp=10", bus.inst_addr_ok,
               bus.data_addr_ok);
    end
    tick();
    bus.inst_req = 1'b0;
    bus.arready  = 1'b1;
    mid();
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arsize}
        !== {1'b1, 4'd0, 32'h1C00_0000, 3'd2}) begin
      failures++;
      $display("FAIL single_ar got=%b/%h/%h/%h exp=1/0/1c000000/2",
               bus.arvalid, bus.arid, bus.araddr, bus.arsize);
    end
    tick();
    bus.arready = 1'b0;
    checks++;
    if (bus.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_ar_drop got=%b exp=0", bus.arvalid);
    end
    repeat (2) tick();
    bus.rvalid = 1'b1;
    bus.rid    = 4'd0;
    bus.rdata  = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0;
    checks++;
    if ({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}
        !== {2'b10, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL single_rdata got=%b%b/%h exp=10/deadbeef",
               bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata);
    end
    tick();
    checks++;
    if (bus.inst_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse got=%b exp=0", bus.inst_data_ok);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h100;
    bus.inst_size = 2'd2;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h200;
    bus.data_size = 2'd1;
    mid();
    checks++;
    if ({bus.data_addr_ok, bus.inst_addr_ok} !== 2'b10) begin
      failures++;
      $display("FAIL prio_grant got=%b%b exp=10", bus.data_addr_ok,
               bus.inst_addr_ok);
    end
    tick();
    bus.data_req = 1'b0;
    bus.arready  = 1'b1;
    mid();
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arsize, bus.inst_addr_ok}
        !== {1'b1, 4'd1, 32'h200, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL prio_ar_data got=%b/%h/%h/%h/%b exp=1/1/200/1/0",
               bus.arvalid, bus.arid, bus.araddr, bus.arsize,
               bus.inst_addr_ok);
    end
    tick();
    bus.arready = 1'b0;
    mid();
    checks++;
    if (bus.inst_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL prio_inst_next got=%b exp=1", bus.inst_addr_ok);
    end
    tick();
    bus.inst_req = 1'b0;
    bus.arready  = 1'b1;
    mid();
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr}
        !== {1'b1, 4'd0, 32'h100}) begin
      failures++;
      $display("FAIL prio_ar_inst got=%b/%h/%h exp=1/0/100",
               bus.arvalid, bus.arid, bus.araddr);
    end
    tick();
    bus.arready = 1'b0;
  endtask

  task automatic test_full_stall();
    do_reset();
    data_rd(32'h300);
    data_rd(32'h304);
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h308;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h400;
    mid();
    checks++;
    if ({bus.data_addr_ok, bus.inst_addr_ok} !== 2'b01) begin
      failures++;
      $display("FAIL full_stall got=%b%b exp=01", bus.data_addr_ok,
               bus.inst_addr_ok);
    end
    tick();
    bus.inst_req = 1'b0;
    bus.arready  = 1'b1;
    tick();
    bus.arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      checks++;
      if (bus.data_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL full_hold%0d got=%b exp=0", k, bus.data_addr_ok);
      end
      tick();
    end
    bus.rvalid = 1'b1;
    bus.rid    = 4'd1;
    bus.rdata  = 32'h5555_AAAA;
    tick();
    bus.rvalid = 1'b0;
    mid();
    checks++;
    if ({bus.data_addr_ok, bus.data_data_ok} !== 2'b11) begin
      failures++;
      $display("FAIL full_release got=%b%b exp=11", bus.data_addr_ok,
               bus.data_data_ok);
    end
    tick();
    bus.data_req = 1'b0;
    mid();
    checks++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h308}) begin
      failures++;
      $display("FAIL full_ar got=%b/%h exp=1/308", bus.arvalid,
               bus.araddr);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    data_rd(32'h500);
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h600;
    tick();
    bus.data_req = 1'b0;
    bus.arready  = 1'b1;
    bus.rvalid   = 1'b1;
    bus.rid      = 4'd1;
    bus.rdata    = 32'hA5A5_0001;
    tick();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    checks++;
    if ({bus.data_data_ok, bus.data_rdata} !== {1'b1, 32'hA5A5_0001}) begin
      failures++;
      $display("FAIL same_data_ok got=%b/%h exp=1/a5a50001",
               bus.data_data_ok, bus.data_rdata);
    end
    bus.data_req = 1'b1;
    mid();
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL same_cnt_one got=%b exp=1", bus.data_addr_ok);
    end
    tick();
    bus.data_req = 1'b0;
    bus.arready  = 1'b1;
    tick();
    bus.arready  = 1'b0;
    bus.data_req = 1'b1;
    mid();
    checks++;
    if (bus.data_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL same_cnt_full got=%b exp=0", bus.data_addr_ok);
    end
    tick();
    bus.data_req = 1'b0;
  endtask

  task automatic test_bad_rid();
    do_reset();
    bus.rvalid = 1'b1;
    bus.rid    = 4'd5;
    bus.rdata  = 32'h1234_5678;
    tick();
    bus.rvalid = 1'b0;
    checks++;
    if ({bus.inst_data_ok, bus.data_data_ok, bus.rid_err} !== 3'b001) begin
      failures++;
      $display("FAIL bad_rid got=%b%b%b exp=001", bus.inst_data_ok,
               bus.data_data_ok, bus.rid_err);
    end
    repeat (3) tick();
    checks++;
    if (bus.rid_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_rid_sticky got=%b exp=1", bus.rid_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_rd(32'h700);
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h704;
    tick();
    bus.data_req = 1'b0;
    mid();
    checks++;
    if (bus.arvalid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got=%b exp=1", bus.arvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.arvalid, bus.araddr, bus.rready} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got=%b/%h/%b exp=0/0/0", bus.arvalid,
               bus.araddr, bus.rready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.data_req = 1'b1;
    mid();
    checks++;
    if ({bus.arvalid, bus.data_addr_ok} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_idle got=%b%b exp=01", bus.arvalid,
               bus.data_addr_ok);
    end
    bus.data_req = 1'b0;
    tick();
    bus.rvalid = 1'b1;
    bus.rid    = 4'd1;
    tick();
    bus.rvalid = 1'b0;
    checks++;
    if (bus.rid_err !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_stale got=%b exp=1", bus.rid_err);
    end
  endtask

  // Transaction-level model: one pending AR, per-ID outstanding counts.
  task automatic test_random();
    int          cnt [2];
    bit          busy;
    logic [3:0]  pid;
    logic [31:0] paddr;
    logic [2:0]  psize;
    bit          eok [2];
    logic [31:0] erd [2];
    bit          gd;
    bit          gi;
    int          id;
    do_reset();
    cnt   = '{0, 0};
    busy  = 1'b0;
    pid   = 4'd0;
    paddr = 32'd0;
    psize = 3'd0;
    erd   = '{32'd0, 32'd0};
    for (int n = 0; n < 400; n++) begin
      bus.inst_req  = 1'($urandom % 2);
      bus.inst_addr = $urandom;
      bus.inst_size = 2'($urandom % 4);
      bus.data_req  = 1'($urandom % 2);
      bus.data_addr = $urandom;
      bus.data_size = 2'($urandom % 4);
      bus.arready   = ($urandom % 3) != 0;
      id = int'($urandom % 2);
      bus.rid    = 4'(id);
      bus.rdata  = $urandom;
      bus.rvalid = (cnt[id] > 0) && ($urandom % 2 == 1);
      gd = !busy && bus.data_req && cnt[1] < MAX_OUT;
      gi = !busy && !gd && bus.inst_req && cnt[0] < MAX_OUT;
      mid();
      checks++;
      if ({bus.data_addr_ok, bus.inst_addr_ok, bus.arvalid}
          !== {gd, gi, busy}) begin
        failures++;
        $display("FAIL rnd_grant n=%0d got=%b%b%b exp=%b%b%b", n,
                 bus.data_addr_ok, bus.inst_addr_ok, bus.arvalid,
                 gd, gi, busy);
      end
      if (busy) begin
        checks++;
        if ({bus.arid, bus.araddr, bus.arsize} !== {pid, paddr, psize}) begin
          failures++;
          $display("FAIL rnd_ar n=%0d got=%h/%h/%h exp=%h/%h/%h", n,
                   bus.arid, bus.araddr, bus.arsize, pid, paddr, psize);
        end
      end
      eok = '{1'b0, 1'b0};
      if (bus.rvalid) begin
        cnt[id]--;
        eok[id] = 1'b1;
        erd[id] = bus.rdata;
      end
      if (busy) begin
        if (bus.arready) begin
          cnt[int'(pid)]++;
          busy = 1'b0;
        end
      end else if (gd) begin
        busy  = 1'b1;
        pid   = 4'd1;
        paddr = bus.data_addr;
        psize = {1'b0, bus.data_size};
      end else if (gi) begin
        busy  = 1'b1;
        pid   = 4'd0;
        paddr = bus.inst_addr;
        psize = {1'b0, bus.inst_size};
      end
      tick();
      checks++;
      if ({bus.inst_data_ok, bus.data_data_ok, bus.rid_err}
          !== {eok[0], eok[1], 1'b0}) begin
        failures++;
        $display("FAIL rnd_data_ok n=%0d got=%b%b%b exp=%b%b0", n,
                 bus.inst_data_ok, bus.data_data_ok, bus.rid_err,
                 eok[0], eok[1]);
      end
      if (eok[0] || eok[1]) begin
        checks++;
        if ((eok[0] && bus.inst_rdata !== erd[0]) ||
            (eok[1] && bus.data_rdata !== erd[1])) begin
          failures++;
          $display("FAIL rnd_rdata n=%0d got=%h/%h exp=%h/%h", n,
                   bus.inst_rdata, bus.data_rdata, erd[0], erd[1]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_inst();
    test_priority();
    test_full_stall();
    test_same_cycle();
    test_bad_rid();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
